ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have the following ports, clock and reset first: stg_clk  in  1  stage clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high.
REQ-003 pc_in  in  32  PC of the instruction in EX.
REQ-004 rd_in / funct3_in / funct7_in  in  5 / 3 / 7  decoded fields.
REQ-005 imm_in  in  32  sign-extended immediate.
REQ-006 instr_type_in  in  4  encoding: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9-15 NOP.
REQ-007 rs1_data_in / rs2_data_in  in  32 each  operand values.
REQ-008 save_to_reg_in, immediate_used_in, rd_memory_in, wr_memory_in  in  1 each  decoded control flags.
REQ-009 alu_result_out  out  32  registered result or effective address.
REQ-010 store_data_out  out  32  registered rs2_data_in.
REQ-011 rd_out / funct3_out  out  5 / 3  registered copies.
REQ-012 save_to_reg_out, rd_memory_out, wr_memory_out  out  1 each  registered control flags for MEM.
REQ-013 branch_taken  out  1  combinational; drives upstream flush (stg_x).
REQ-014 branch_target  out  32  combinational redirect PC.
REQ-015 stall_out  out  1  combinational; drives upstream hold (stg_ena, 1 = hold).

Function
REQ-016 Operand B SHALL be imm_in when immediate_used_in=1, else rs2_data_in.
REQ-017 ALU ops: RV32I set selected by funct3_in/funct7_in[5] (ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND); shift amount = B[4:0].
REQ-018 LOAD/STORE: rs1+imm. LUI: imm. AUIPC: pc+imm. JAL/JALR: pc+4. All arithmetic is 32-bit, wrapping.
REQ-019 Single-cycle ops: result and control flags SHALL register on the next stg_clk edge (latency 1).
REQ-020 BRANCH per funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; branch_taken=1 iff the condition holds; target = pc+imm.
REQ-021 JAL: branch_taken=1, target = pc+imm. JALR: branch_taken=1, target = (rs1+imm) & ~1.
REQ-022 branch_taken SHALL be 0 for every other type and whenever stall_out=1.
REQ-023 save_to_reg_out SHALL be forced to 0 when rd_in=0.
REQ-024 NOP types SHALL register as a bubble: all control outputs 0, rd_out=0.
REQ-025 An M op is instr_type_in=0 with funct7_in=0000001: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3.
REQ-026 The M-op FSM SHALL have three states:
  - IDLE: an M op present -> capture operand magnitudes, sign flags and special-case flags; clear counter; go to BUSY.
  - BUSY: one shift-add (MUL*) or restoring-subtract (DIV/REM) step per cycle; after step 32 (counter=31) go to DONE.
  - DONE: sign-correct and select the result; go to IDLE.
REQ-027 stall_out SHALL equal (IDLE and M op present) or BUSY; it SHALL be 0 in DONE.
REQ-028 Every edge with stall_out=1 SHALL register a bubble, so MEM never sees a duplicate.
REQ-029 The edge leaving DONE SHALL register the M result; total latency is 34 edges from first presentation.
REQ-030 The FSM SHALL NOT restart on the instruction it just completed; on the DONE edge the upstream stage loads the next instruction.
REQ-031 Divide by zero: quotient = 0xFFFFFFFF and remainder = dividend (DIVU/REMU and signed alike).
REQ-032 Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
REQ-033 Special cases SHALL still take the full 34-cycle latency.
REQ-034 MULH returns the signed x signed upper 32 bits, MULHSU signed x unsigned, MULHU unsigned x unsigned.

Reset
REQ-035 reset=1 SHALL immediately force FSM to IDLE, counter to 0, and every registered output to 0.
REQ-036 Asserting reset mid-multiply or mid-divide SHALL abandon the operation with no result written.
REQ-037 The first edge after reset release SHALL process inputs normally.

Verification
REQ-038 ADD rs1=5, rs2=7, rd=3 -> next edge: alu_result_out=12, rd_out=3, save_to_reg_out=1.
REQ-039 BEQ rs1=rs2=9, pc=0x100, imm=0x20 -> same cycle: branch_taken=1, branch_target=0x120; BNE with the same operands -> branch_taken=0.
REQ-040 MUL 0xFFFFFFFF x 3 (signed, -1 x 3), rd=5:
  - stall_out=1 for 33 cycles, bubbles registered throughout;
  - edge 34: alu_result_out=0xFFFFFFFD, save_to_reg_out=1;
  - the following cycle: stall_out=0.
REQ-041 DIV 7/0 -> quotient 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each after 34 edges.
REQ-042 reset pulsed at BUSY counter=10 -> all outputs 0 and stall_out=0 immediately; a subsequent ADD completes normally.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle RV32I ALU/branch resolution plus an iterative
// 32-step multiplier/divider for the M extension that holds the upstream stage.
module ex_stage (
    input  logic        stg_clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic [6:0]  funct7_in,
    input  logic [31:0] imm_in,
    input  logic [3:0]  instr_type_in,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic        save_to_reg_in,
    input  logic        immediate_used_in,
    input  logic        rd_memory_in,
    input  logic        wr_memory_in,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  rd_out,
    output logic [2:0]  funct3_out,
    output logic        save_to_reg_out,
    output logic        rd_memory_out,
    output logic        wr_memory_out,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        stall_out
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 5;

    localparam logic [3:0] T_R      = 4'd0;
    localparam logic [3:0] T_I      = 4'd1;
    localparam logic [3:0] T_LOAD   = 4'd2;
    localparam logic [3:0] T_STORE  = 4'd3;
    localparam logic [3:0] T_BRANCH = 4'd4;
    localparam logic [3:0] T_JAL    = 4'd5;
    localparam logic [3:0] T_JALR   = 4'd6;
    localparam logic [3:0] T_LUI    = 4'd7;
    localparam logic [3:0] T_AUIPC  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_a, r_hi, r_lo, r_dvd;
    logic [2:0]        r_f3;
    logic              r_is_div, r_neg, r_neg_rem, r_div0, r_ovf;

    logic [XLEN-1:0]   w_b, w_alu, w_res, w_sra, w_mag_a, w_mag_b, w_m_res;
    logic [XLEN-1:0]   w_div_rem, w_q, w_r;
    logic [XLEN:0]     w_mul_sum, w_div_sh;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [4:0]        w_shamt;
    logic              w_is_m, w_is_nop, w_cond, w_sa, w_sb, w_a_neg, w_b_neg, w_div_ge;
    logic              w_save;

    assign w_b      = immediate_used_in ? imm_in : rs2_data_in;
    assign w_shamt  = w_b[4:0];
    assign w_sra    = $unsigned($signed(rs1_data_in) >>> w_shamt);
    assign w_is_m   = (instr_type_in == T_R) && (funct7_in == 7'b0000001);
    assign w_is_nop = instr_type_in > T_AUIPC;
    assign w_save   = save_to_reg_in && (rd_in != 5'd0);

    // Hold upstream while an M op is waiting to start or iterating.
    assign stall_out = !reset && (((r_state == S_IDLE) && w_is_m) || (r_state == S_BUSY));

    // RV32I integer ALU.
    always_comb begin
        w_alu = '0;
        case (funct3_in)
            3'b000:  w_alu = ((instr_type_in == T_R) && funct7_in[5]) ? rs1_data_in - w_b
                                                                     : rs1_data_in + w_b;
            3'b001:  w_alu = rs1_data_in << w_shamt;
            3'b010:  w_alu = XLEN'($signed(rs1_data_in) < $signed(w_b));
            3'b011:  w_alu = XLEN'(rs1_data_in < w_b);
            3'b100:  w_alu = rs1_data_in ^ w_b;
            3'b101:  w_alu = funct7_in[5] ? w_sra : (rs1_data_in >> w_shamt);
            3'b110:  w_alu = rs1_data_in | w_b;
            default: w_alu = rs1_data_in & w_b;
        endcase
    end

    // Per-type single-cycle result / effective address.
    always_comb begin
        w_res = w_alu;
        case (instr_type_in)
            T_LOAD, T_STORE: w_res = rs1_data_in + imm_in;
            T_LUI:           w_res = imm_in;
            T_AUIPC:         w_res = pc_in + imm_in;
            T_JAL, T_JALR:   w_res = pc_in + 32'd4;
            default:         w_res = w_alu;
        endcase
    end

    // Branch condition on the raw register operands.
    always_comb begin
        w_cond = 1'b0;
        case (funct3_in)
            3'b000:  w_cond = rs1_data_in == rs2_data_in;
            3'b001:  w_cond = rs1_data_in != rs2_data_in;
            3'b100:  w_cond = $signed(rs1_data_in) <  $signed(rs2_data_in);
            3'b101:  w_cond = $signed(rs1_data_in) >= $signed(rs2_data_in);
            3'b110:  w_cond = rs1_data_in <  rs2_data_in;
            3'b111:  w_cond = rs1_data_in >= rs2_data_in;
            default: w_cond = 1'b0;
        endcase
    end

    assign branch_taken  = !stall_out && (((instr_type_in == T_BRANCH) && w_cond) ||
                                          (instr_type_in == T_JAL) || (instr_type_in == T_JALR));
    assign branch_target = (instr_type_in == T_JALR) ? ((rs1_data_in + imm_in) & ~32'd1)
                                                     : (pc_in + imm_in);

    // Operand signedness by funct3: MUL/MULH ss, MULHSU su, MULHU uu, DIV/REM ss, DIVU/REMU uu.
    assign w_sa    = funct3_in[2] ? !funct3_in[0] : (funct3_in[1:0] != 2'b11);
    assign w_sb    = funct3_in[2] ? !funct3_in[0] : !funct3_in[1];
    assign w_a_neg = w_sa && rs1_data_in[31];
    assign w_b_neg = w_sb && w_b[31];
    assign w_mag_a = w_a_neg ? (32'd0 - rs1_data_in) : rs1_data_in;
    assign w_mag_b = w_b_neg ? (32'd0 - w_b) : w_b;

    // Iteration datapath: shift-add multiply and restoring divide share {r_hi, r_lo}.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);
    assign w_div_sh  = {r_hi, r_lo[31]};
    assign w_div_ge  = w_div_sh >= {1'b0, r_a};
    assign w_div_rem = w_div_ge ? XLEN'(w_div_sh - {1'b0, r_a}) : w_div_sh[XLEN-1:0];

    // Sign correction and special-case selection of the finished M result.
    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg ? (64'd0 - w_prod) : w_prod;
    assign w_q      = r_neg ? (32'd0 - r_lo) : r_lo;
    assign w_r      = r_neg_rem ? (32'd0 - r_hi) : r_hi;

    always_comb begin
        w_m_res = '0;
        case (r_f3)
            3'b000:         w_m_res = w_prod_s[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         w_m_res = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101: w_m_res = r_div0 ? 32'hFFFF_FFFF : (r_ovf ? 32'h8000_0000 : w_q);
            default:        w_m_res = r_div0 ? r_dvd : (r_ovf ? 32'd0 : w_r);
        endcase
    end

    // M-op sequencer: capture, 32 iteration steps, then one result cycle.
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dvd     <= '0;
            r_f3      <= '0;
            r_is_div  <= 1'b0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_is_m) begin
                    r_cnt     <= '0;
                    r_f3      <= funct3_in;
                    r_is_div  <= funct3_in[2];
                    r_neg     <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    r_div0    <= w_b == 32'd0;
                    r_ovf     <= funct3_in[2] && w_sa && (rs1_data_in == 32'h8000_0000) &&
                                 (w_b == 32'hFFFF_FFFF);
                    r_dvd     <= rs1_data_in;
                    r_hi      <= '0;
                    r_a       <= funct3_in[2] ? w_mag_b : w_mag_a;
                    r_lo      <= funct3_in[2] ? w_mag_a : w_mag_b;
                    r_state   <= S_BUSY;
                end
                S_BUSY: begin
                    if (r_is_div) begin
                        r_hi <= w_div_rem;
                        r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                    end else begin
                        r_hi <= w_mul_sum[XLEN:1];
                        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(31)) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // EX/MEM pipeline register: bubble on stall or NOP, M result on the DONE edge.
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset || stall_out) begin
            alu_result_out  <= '0;
            store_data_out  <= '0;
            rd_out          <= '0;
            funct3_out      <= '0;
            save_to_reg_out <= 1'b0;
            rd_memory_out   <= 1'b0;
            wr_memory_out   <= 1'b0;
        end else if (r_state == S_DONE) begin
            alu_result_out  <= w_m_res;
            store_data_out  <= rs2_data_in;
            rd_out          <= rd_in;
            funct3_out      <= funct3_in;
            save_to_reg_out <= w_save;
            rd_memory_out   <= 1'b0;
            wr_memory_out   <= 1'b0;
        end else if (w_is_nop) begin
            alu_result_out  <= '0;
            store_data_out  <= '0;
            rd_out          <= '0;
            funct3_out      <= '0;
            save_to_reg_out <= 1'b0;
            rd_memory_out   <= 1'b0;
            wr_memory_out   <= 1'b0;
        end else begin
            alu_result_out  <= w_res;
            store_data_out  <= rs2_data_in;
            rd_out          <= rd_in;
            funct3_out      <= funct3_in;
            save_to_reg_out <= w_save;
            rd_memory_out   <= rd_memory_in;
            wr_memory_out   <= wr_memory_in;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage with hand-computed expected values.
module tb_ex_stage;
    logic        stg_clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, imm_in, rs1_data_in, rs2_data_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic [6:0]  funct7_in;
    logic [3:0]  instr_type_in;
    logic        save_to_reg_in, immediate_used_in, rd_memory_in, wr_memory_in;
    logic [31:0] alu_result_out, store_data_out, branch_target;
    logic [4:0]  rd_out;
    logic [2:0]  funct3_out;
    logic        save_to_reg_out, rd_memory_out, wr_memory_out, branch_taken, stall_out;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage dut (
        .stg_clk(stg_clk), .reset(reset), .pc_in(pc_in), .rd_in(rd_in),
        .funct3_in(funct3_in), .funct7_in(funct7_in), .imm_in(imm_in),
        .instr_type_in(instr_type_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .save_to_reg_in(save_to_reg_in), .immediate_used_in(immediate_used_in),
        .rd_memory_in(rd_memory_in), .wr_memory_in(wr_memory_in),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out), .rd_out(rd_out),
        .funct3_out(funct3_out), .save_to_reg_out(save_to_reg_out),
        .rd_memory_out(rd_memory_out), .wr_memory_out(wr_memory_out),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall_out(stall_out)
    );

    always #5 stg_clk = ~stg_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ty, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] pc, input logic [4:0] rd, input logic sv,
                         input logic iu, input logic rm, input logic wm);
        instr_type_in = ty; funct3_in = f3; funct7_in = f7;
        rs1_data_in = a; rs2_data_in = b; imm_in = im; pc_in = pc; rd_in = rd;
        save_to_reg_in = sv; immediate_used_in = iu; rd_memory_in = rm; wr_memory_in = wm;
    endtask

    task automatic step();
        @(posedge stg_clk);
        #1;
    endtask

    task automatic nop();
        drive(4'd9, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Present an M op with rd=5, count stall cycles, then check the registered result.
    task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int   n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        drive(4'd0, f3, 7'h01, a, b, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        while (stall_out && n < 40) begin
            n++;
            step();
            if (save_to_reg_out !== 1'b0 || rd_out !== 5'd0) bad = 1'b1;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'd33);
        check({tag, "_bubbles"}, {31'd0, bad}, 32'd0);
        step();
        check(tag, alu_result_out, exp);
        check({tag, "_save"}, {31'd0, save_to_reg_out}, 32'd1);
        nop();
        #1;
        check({tag, "_stall_after"}, {31'd0, stall_out}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        nop();
        repeat (2) step();
        check("rst_alu", alu_result_out, 32'd0);
        check("rst_save", {31'd0, save_to_reg_out}, 32'd0);
        check("rst_stall", {31'd0, stall_out}, 32'd0);

        reset = 1'b0;
        // ADD 5+7 rd=3
        drive(4'd0, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("add", alu_result_out, 32'd12);
        check("add_rd", {27'd0, rd_out}, 32'd3);
        check("add_save", {31'd0, save_to_reg_out}, 32'd1);

        drive(4'd0, 3'b000, 7'h20, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("sub", alu_result_out, 32'hFFFF_FFFE);

        drive(4'd0, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("rd0_save", {31'd0, save_to_reg_out}, 32'd0);

        drive(4'd0, 3'b001, 7'h00, 32'd1, 32'h21, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("sll_shamt", alu_result_out, 32'd2);

        drive(4'd0, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("slt", alu_result_out, 32'd1);
        drive(4'd0, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("sltu", alu_result_out, 32'd0);

        drive(4'd0, 3'b100, 7'h00, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("xor", alu_result_out, 32'h0000_0FF0);

        drive(4'd1, 3'b101, 7'h20, 32'h8000_0000, 32'd0, 32'h0000_0404, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("srai", alu_result_out, 32'hF800_0000);

        drive(4'd2, 3'b010, 7'h00, 32'h0000_1000, 32'd0, 32'hFFFF_FFFC, 32'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check("load_ea", alu_result_out, 32'h0000_0FFC);
        check("load_rdmem", {31'd0, rd_memory_out}, 32'd1);

        drive(4'd3, 3'b010, 7'h00, 32'h0000_2000, 32'hDEAD_BEEF, 32'd8, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check("store_ea", alu_result_out, 32'h0000_2008);
        check("store_data", store_data_out, 32'hDEAD_BEEF);
        check("store_wrmem", {31'd0, wr_memory_out}, 32'd1);

        drive(4'd7, 3'b000, 7'h00, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("lui", alu_result_out, 32'h1234_5000);

        drive(4'd8, 3'b000, 7'h00, 32'd0, 32'd0, 32'h0000_1000, 32'h100, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("auipc", alu_result_out, 32'h0000_1100);

        drive(4'd5, 3'b000, 7'h00, 32'd0, 32'd0, 32'h40, 32'h200, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("jal_taken", {31'd0, branch_taken}, 32'd1);
        check("jal_target", branch_target, 32'h240);
        step();
        check("jal_link", alu_result_out, 32'h204);

        drive(4'd6, 3'b000, 7'h00, 32'h301, 32'd0, 32'h10, 32'h200, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("jalr_target", branch_target, 32'h310);

        drive(4'd4, 3'b000, 7'h00, 32'd9, 32'd9, 32'h20, 32'h100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("beq_taken", {31'd0, branch_taken}, 32'd1);
        check("beq_target", branch_target, 32'h120);
        funct3_in = 3'b001;
        #1;
        check("bne_taken", {31'd0, branch_taken}, 32'd0);
        drive(4'd4, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("blt_taken", {31'd0, branch_taken}, 32'd1);
        funct3_in = 3'b110;
        #1;
        check("bltu_taken", {31'd0, branch_taken}, 32'd0);

        drive(4'd9, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("nop_taken", {31'd0, branch_taken}, 32'd0);
        step();
        check("nop_save", {31'd0, save_to_reg_out}, 32'd0);
        check("nop_rd", {27'd0, rd_out}, 32'd0);
        check("nop_rdmem", {31'd0, rd_memory_out}, 32'd0);

        run_m("mul",    3'b000, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD);
        run_m("mulh",   3'b001, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFF);
        run_m("mulhsu", 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_m("mulhu",  3'b011, 32'hFFFF_FFFF, 32'd3,         32'd2);
        run_m("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_m("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_m("divu",   3'b101, 32'd100,       32'd7,         32'd14);
        run_m("remu",   3'b111, 32'd100,       32'd7,         32'd2);
        run_m("div0",   3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF);
        run_m("rem0",   3'b110, 32'd7,         32'd0,         32'd7);
        run_m("divu0",  3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF);
        run_m("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_m("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Reset while the divider sits at counter=10.
        drive(4'd0, 3'b100, 7'h01, 32'd1000, 32'd3, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (11) step();
        check("mid_stall_busy", {31'd0, stall_out}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_stall", {31'd0, stall_out}, 32'd0);
        check("mid_rst_alu", alu_result_out, 32'd0);
        check("mid_rst_save", {31'd0, save_to_reg_out}, 32'd0);
        step();
        reset = 1'b0;
        drive(4'd0, 3'b000, 7'h00, 32'd20, 32'd22, 32'd0, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("post_rst_stall", {31'd0, stall_out}, 32'd0);
        step();
        check("post_rst_add", alu_result_out, 32'd42);
        check("post_rst_rd", {27'd0, rd_out}, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
